snoop_responder: RTL and testbench

Last-level cache snoop responder: the receive side of the shared-bus MESI protocol, answering bus operations issued by other caches. For each snooped READ, WRITE, INVALIDATE or RWIM it:
- looks up the local tag/MESI array;
- drives the snoop result (NOHIT/HIT/HITM);
- sends the required L1 messages and writes back modified data;
- commits the next MESI state.

It sits beside the cache controller, sharing the tag array through a lookup port and an update port.

---
 rtl/snoop_responder.sv | 244 ++++++++++++++++++++++++
 tb/tb_snoop_responder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_responder.sv
// Snoop responder for the shared-bus MESI protocol: looks up the tag array, answers the bus,
// drives L1 messages and write-backs, and commits the new line state. Build option: SNOOP_PROTO_CHECK_EN.
module snoop_responder #(
  parameter int ADDR_BITS   = 32,
  parameter int OFFSET_BITS = 6,
  parameter int INDEX_BITS  = 14,
  parameter int TAG_BITS    = 12,
  parameter int WAY_BITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  snoop_valid,
  output logic                  snoop_ready,
  input  logic [1:0]            snoop_op,
  input  logic [ADDR_BITS-1:0]  snoop_addr,
  output logic                  lkp_valid,
  output logic [INDEX_BITS-1:0] lkp_index,
  output logic [TAG_BITS-1:0]   lkp_tag,
  input  logic                  lkp_hit,
  input  logic [WAY_BITS-1:0]   lkp_way,
  input  logic [1:0]            lkp_mesi,
  output logic                  upd_valid,
  output logic [INDEX_BITS-1:0] upd_index,
  output logic [WAY_BITS-1:0]   upd_way,
  output logic [1:0]            upd_mesi,
  output logic                  result_valid,
  output logic [1:0]            snoop_result,
  output logic                  msg_valid,
  input  logic                  msg_ready,
  output logic [1:0]            msg_type,
  output logic [ADDR_BITS-1:0]  msg_addr,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [ADDR_BITS-1:0]  wb_addr,
  output logic                  snoop_done,
  output logic                  proto_err
);

  localparam logic [1:0] OP_READ = 2'd0, OP_WRITE = 2'd1, OP_INV = 2'd2, OP_RWIM = 2'd3;
  localparam logic [1:0] ST_M = 2'd0, ST_E = 2'd1, ST_S = 2'd2, ST_I = 2'd3;
  localparam logic [1:0] R_NOHIT = 2'd0, R_HIT = 2'd1, R_HITM = 2'd2;
  localparam logic [1:0] MT_GETLINE = 2'd0, MT_INVLINE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_RESOLVE, S_MSG1, S_WB, S_MSG2, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [WAY_BITS-1:0]    way_q, way_d;
  logic [1:0]             mesi_q, mesi_d;
  logic                   upd_en_q, upd_en_d;
  logic                   gl_q, gl_d;
  logic                   wb_q, wb_d;
  logic                   inv_q, inv_d;
  logic [1:0]             res_q, res_d;
  logic                   res_vld_q, res_vld_d;

  logic [1:0] r_res, r_mesi;
  logic       r_gl, r_wb, r_inv, r_upd;
`ifdef SNOOP_PROTO_CHECK_EN
  logic       r_perr;
  logic       perr_q, perr_d;
`endif

  // Action table: what the looked-up line state demands for the captured bus op.
  always_comb begin
    r_res  = R_NOHIT;
    r_mesi = ST_I;
    r_gl   = 1'b0;
    r_wb   = 1'b0;
    r_inv  = 1'b0;
    r_upd  = 1'b0;
`ifdef SNOOP_PROTO_CHECK_EN
    r_perr = 1'b0;
`endif
    if (lkp_hit) begin
      case (op_q)
        OP_READ: begin
          case (lkp_mesi)
            ST_M: begin
              r_res = R_HITM; r_gl = 1'b1; r_wb = 1'b1; r_upd = 1'b1; r_mesi = ST_S;
            end
            ST_E: begin
              r_res = R_HIT; r_upd = 1'b1; r_mesi = ST_S;
            end
            ST_S: r_res = R_HIT;
            default: ;
          endcase
        end
        OP_WRITE: begin
`ifdef SNOOP_PROTO_CHECK_EN
          if (lkp_mesi == ST_M) r_perr = 1'b1;
`endif
        end
        OP_INV: begin
          case (lkp_mesi)
            ST_S: begin
              r_res = R_HIT; r_inv = 1'b1; r_upd = 1'b1;
            end
            ST_M, ST_E: begin
`ifdef SNOOP_PROTO_CHECK_EN
              r_perr = 1'b1;
`else
              r_res = R_HIT; r_inv = 1'b1; r_upd = 1'b1;
`endif
            end
            default: ;
          endcase
        end
        OP_RWIM: begin
          case (lkp_mesi)
            ST_M: begin
              r_res = R_HITM; r_gl = 1'b1; r_wb = 1'b1; r_inv = 1'b1; r_upd = 1'b1;
            end
            ST_E, ST_S: begin
              r_res = R_HIT; r_inv = 1'b1; r_upd = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    way_d     = way_q;
    mesi_d    = mesi_q;
    upd_en_d  = upd_en_q;
    gl_d      = gl_q;
    wb_d      = wb_q;
    inv_d     = inv_q;
    res_d     = res_q;
    res_vld_d = 1'b0;
`ifdef SNOOP_PROTO_CHECK_EN
    perr_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (snoop_valid) begin
          op_d    = snoop_op;
          addr_d  = snoop_addr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: state_d = S_RESOLVE;
      S_RESOLVE: begin
        res_d     = r_res;
        res_vld_d = 1'b1;
`ifdef SNOOP_PROTO_CHECK_EN
        perr_d    = r_perr;
`endif
        way_d     = lkp_way;
        mesi_d    = r_mesi;
        upd_en_d  = r_upd;
        gl_d      = r_gl;
        wb_d      = r_wb;
        inv_d     = r_inv;
        if (r_gl)       state_d = S_MSG1;
        else if (r_wb)  state_d = S_WB;
        else if (r_inv) state_d = S_MSG2;
        else            state_d = S_DONE;
      end
      S_MSG1: begin
        if (msg_ready) begin
          if (wb_q)       state_d = S_WB;
          else if (inv_q) state_d = S_MSG2;
          else            state_d = S_DONE;
        end
      end
      S_WB: begin
        if (wb_ready) state_d = inv_q ? S_MSG2 : S_DONE;
      end
      S_MSG2: begin
        if (msg_ready) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Reset anywhere returns to IDLE; DONE is never reached so no update is committed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= 2'd0;
      addr_q    <= '0;
      way_q     <= '0;
      mesi_q    <= 2'd0;
      upd_en_q  <= 1'b0;
      gl_q      <= 1'b0;
      wb_q      <= 1'b0;
      inv_q     <= 1'b0;
      res_q     <= 2'd0;
      res_vld_q <= 1'b0;
`ifdef SNOOP_PROTO_CHECK_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      way_q     <= way_d;
      mesi_q    <= mesi_d;
      upd_en_q  <= upd_en_d;
      gl_q      <= gl_d;
      wb_q      <= wb_d;
      inv_q     <= inv_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
`ifdef SNOOP_PROTO_CHECK_EN
      perr_q    <= perr_d;
`endif
    end
  end

  assign snoop_ready  = (state_q == S_IDLE);
  assign lkp_valid    = (state_q == S_LOOKUP);
  assign lkp_index    = addr_q[OFFSET_BITS +: INDEX_BITS];
  assign lkp_tag      = addr_q[ADDR_BITS-1 -: TAG_BITS];
  assign upd_valid    = (state_q == S_DONE) && upd_en_q;
  assign upd_index    = addr_q[OFFSET_BITS +: INDEX_BITS];
  assign upd_way      = way_q;
  assign upd_mesi     = mesi_q;
  assign result_valid = res_vld_q;
  assign snoop_result = res_q;
  assign msg_valid    = (state_q == S_MSG1) || (state_q == S_MSG2);
  assign msg_type     = (state_q == S_MSG2) ? MT_INVLINE : MT_GETLINE;
  assign msg_addr     = {addr_q[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign wb_valid     = (state_q == S_WB);
  assign wb_addr      = {addr_q[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign snoop_done   = (state_q == S_DONE);
`ifdef SNOOP_PROTO_CHECK_EN
  assign proto_err    = perr_q;
`else
  assign proto_err    = 1'b0;
`endif

endmodule

// File: tb/tb_snoop_responder.sv
// Randomized bench for snoop_responder with a transaction-level MESI model and per-cycle compare.
module tb_snoop_responder;
`ifdef SNOOP_PROTO_CHECK_EN
  localparam bit PC = 1'b1;
`else
  localparam bit PC = 1'b0;
`endif

  logic clk = 0, rst = 1;
  logic snoop_valid = 0, snoop_ready;
  logic [1:0] snoop_op = 0;
  logic [31:0] snoop_addr = 0;
  logic lkp_valid, lkp_hit = 0;
  logic [13:0] lkp_index;
  logic [11:0] lkp_tag;
  logic [3:0] lkp_way = 0;
  logic [1:0] lkp_mesi = 0;
  logic upd_valid, result_valid, msg_valid, wb_valid, snoop_done, proto_err;
  logic [13:0] upd_index;
  logic [3:0] upd_way;
  logic [1:0] upd_mesi, snoop_result, msg_type;
  logic [31:0] msg_addr, wb_addr;
  logic msg_ready = 1, wb_ready = 1;

  snoop_responder dut (
    .clk(clk), .rst(rst), .snoop_valid(snoop_valid), .snoop_ready(snoop_ready),
    .snoop_op(snoop_op), .snoop_addr(snoop_addr), .lkp_valid(lkp_valid),
    .lkp_index(lkp_index), .lkp_tag(lkp_tag), .lkp_hit(lkp_hit), .lkp_way(lkp_way),
    .lkp_mesi(lkp_mesi), .upd_valid(upd_valid), .upd_index(upd_index), .upd_way(upd_way),
    .upd_mesi(upd_mesi), .result_valid(result_valid), .snoop_result(snoop_result),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_type(msg_type), .msg_addr(msg_addr),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .snoop_done(snoop_done),
    .proto_err(proto_err));

  always #5 clk = ~clk;

  typedef struct {
    int kind;            // 0 msg, 1 wb, 2 upd, 3 done
    logic [1:0] typ;
    logic [31:0] addr;
    logic [13:0] idx;
    logic [3:0] way;
    logic [1:0] mesi;
  } ev_t;

  ev_t evq[$];
  int vecs = 0, errs = 0, cyc = 0;
  int acc_cnt = 0, done_cnt = 0, wbvis = 0;
  int acc_cyc, done_d, n_msg, n_wb, n_upd;
  bit busy = 0, rst_chk = 0, fast, rnd_rdy = 0;
  int msg_stall = 0, wb_stall = 0;
  logic cur_hit = 0;
  logic [3:0] cur_way = 0;
  logic [1:0] cur_mesi = 0;
  logic [1:0] exp_res, last_res, last_upd_mesi, last_mt;
  logic exp_perr, last_perr;
  logic [31:0] exp_a, first_msg_addr, last_wb_addr;
  logic [13:0] last_upd_idx;
  logic [3:0] last_upd_way;
  logic pmv = 0, pmr = 0, pwv = 0, pwr = 0;
  logic [1:0] pmt;
  logic [31:0] pma, pwa;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Rules of the protocol, stated per (op, line state).
  task automatic model(input logic [1:0] op, input logic h, input logic [1:0] m,
                       output logic [1:0] res, output logic perr, output logic gl,
                       output logic wb, output logic inv, output logic upd,
                       output logic [1:0] nm);
    res = 0; perr = 0; gl = 0; wb = 0; inv = 0; upd = 0; nm = 3;
    if (h) begin
      if (op == 0) begin
        if (m == 0) begin res = 2; gl = 1; wb = 1; upd = 1; nm = 2; end
        else if (m == 1) begin res = 1; upd = 1; nm = 2; end
        else if (m == 2) res = 1;
      end else if (op == 1) begin
        if (m == 0) perr = PC;
      end else if (op == 2) begin
        if (m == 2 || (!PC && m != 3)) begin res = 1; inv = 1; upd = 1; end
        else if (m != 3) perr = 1;
      end else begin
        if (m == 0) begin res = 2; gl = 1; wb = 1; inv = 1; upd = 1; end
        else if (m != 3) begin res = 1; inv = 1; upd = 1; end
      end
    end
  endtask

  // Lookup responder: valid data only in the cycle after lkp_valid, noise otherwise.
  initial begin
    logic seen;
    forever begin
      @(negedge clk); seen = lkp_valid;
      @(posedge clk); #1;
      if (seen) begin lkp_hit = cur_hit; lkp_way = cur_way; lkp_mesi = cur_mesi; end
      else begin lkp_hit = 1'($urandom); lkp_way = 4'($urandom); lkp_mesi = 2'($urandom); end
    end
  end

  // Ready driver plus compare process, all at the falling edge.
  always @(negedge clk) begin
    int d;
    ev_t e, ne;
    logic [1:0] res, nm;
    logic perr, gl, wb, inv, upd;
    if (rst) begin
      busy = 0; evq.delete(); rst_chk = 1;
      pmv = 0; pwv = 0; msg_ready = 1; wb_ready = 1;
    end else begin
      if (rst_chk) begin
        chk("reset_outputs", {snoop_ready, lkp_valid, lkp_index, lkp_tag, upd_valid, upd_index,
            upd_way, upd_mesi, result_valid, snoop_result, msg_valid, msg_type, msg_addr,
            wb_valid, wb_addr, snoop_done, proto_err}, {1'b1, 121'd0});
        rst_chk = 0;
      end
      if (msg_valid && msg_stall > 0) begin msg_ready = 0; msg_stall--; end
      else msg_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wb_valid && wb_stall > 0) begin wb_ready = 0; wb_stall--; end
      else wb_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wb_valid) wbvis++;
      if (pmv && !pmr) chk("msg_hold", {msg_valid, msg_type, msg_addr}, {1'b1, pmt, pma});
      if (pwv && !pwr) chk("wb_hold", {wb_valid, wb_addr}, {1'b1, pwa});
      if (busy) begin
        d = cyc - acc_cyc;
        chk("snoop_ready_busy", snoop_ready, 0);
        chk("lkp_valid", lkp_valid, d == 1);
        if (d == 1) chk("lkp_key", {lkp_tag, lkp_index}, {exp_a[31:20], exp_a[19:6]});
        chk("result_valid", result_valid, d == 3);
        chk("proto_err", proto_err, (d == 3) ? exp_perr : 1'b0);
        if (d == 3) begin
          chk("snoop_result", snoop_result, exp_res);
          last_res = snoop_result; last_perr = proto_err;
        end
        if (msg_valid && msg_ready) begin
          n_msg++;
          if (n_msg == 1) first_msg_addr = msg_addr;
          last_mt = msg_type;
          if (evq.size() == 0) chk("msg_unexpected", 1, 0);
          else begin
            e = evq.pop_front();
            chk("msg", {32'(e.kind), e.typ, e.addr}, {32'd0, msg_type, msg_addr});
          end
        end
        if (wb_valid && wb_ready) begin
          n_wb++; last_wb_addr = wb_addr;
          if (evq.size() == 0) chk("wb_unexpected", 1, 0);
          else begin
            e = evq.pop_front();
            chk("wb", {32'(e.kind), e.addr}, {32'd1, wb_addr});
          end
        end
        if (upd_valid) begin
          n_upd++; last_upd_idx = upd_index; last_upd_way = upd_way; last_upd_mesi = upd_mesi;
          if (evq.size() == 0) chk("upd_unexpected", 1, 0);
          else begin
            e = evq.pop_front();
            chk("upd", {32'(e.kind), e.idx, e.way, e.mesi}, {32'd2, upd_index, upd_way, upd_mesi});
          end
        end
        if (snoop_done) begin
          done_d = d;
          if (evq.size() == 0) chk("done_unexpected", 1, 0);
          else begin
            e = evq.pop_front();
            chk("done", 32'(e.kind), 32'd3);
          end
          if (fast) chk("done_latency", d, 3);
          busy = 0; done_cnt++;
        end
        if (d > 500) begin
          chk("watchdog", 1, 0);
          $display("FAIL watchdog: transaction never completed");
          $fatal(1, "hang");
        end
      end else begin
        chk("idle_outputs", {snoop_ready, lkp_valid, result_valid, msg_valid, wb_valid,
            upd_valid, snoop_done, proto_err}, 8'b1000_0000);
        if (snoop_valid && snoop_ready) begin
          busy = 1; acc_cyc = cyc; acc_cnt++; exp_a = snoop_addr;
          n_msg = 0; n_wb = 0; n_upd = 0;
          model(snoop_op, cur_hit, cur_mesi, res, perr, gl, wb, inv, upd, nm);
          exp_res = res; exp_perr = perr; fast = !(gl || wb || inv);
          ne.addr = snoop_addr & 32'hFFFF_FFC0; ne.idx = 14'(snoop_addr >> 6);
          ne.way = cur_way; ne.mesi = nm;
          if (gl) begin ne.kind = 0; ne.typ = 0; evq.push_back(ne); end
          if (wb) begin ne.kind = 1; ne.typ = 0; evq.push_back(ne); end
          if (inv) begin ne.kind = 0; ne.typ = 2; evq.push_back(ne); end
          if (upd) begin ne.kind = 2; ne.typ = 0; evq.push_back(ne); end
          ne.kind = 3; ne.typ = 0; evq.push_back(ne);
        end
      end
      pmv = msg_valid; pmr = msg_ready; pmt = msg_type; pma = msg_addr;
      pwv = wb_valid; pwr = wb_ready; pwa = wb_addr;
    end
  end

  task automatic xact(input logic [1:0] op, input logic [31:0] a, input logic h,
                      input logic [3:0] w, input logic [1:0] m);
    int old;
    bit ok;
    cur_hit = h; cur_way = w; cur_mesi = m;
    snoop_op = op; snoop_addr = a; snoop_valid = 1;
    old = acc_cnt; ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin @(posedge clk); #2; ok = (acc_cnt != old); end
    chk("accept_seen", ok, 1);
    snoop_valid = 1'($urandom); snoop_op = 2'($urandom); snoop_addr = $urandom;
    old = done_cnt; ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin @(posedge clk); #2; ok = (done_cnt != old); end
    chk("done_seen", ok, 1);
    snoop_valid = 0;
  endtask

  initial begin
    int old;
    bit ok;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    @(posedge clk); #2;

    // READ hit in M: HITM, GETLINE, write-back, M->S.
    xact(0, 32'h1234_5680, 1, 4'd3, 0);
    chk("t1_result", last_res, 2);
    chk("t1_msg_addr", first_msg_addr, 32'h1234_5680);
    chk("t1_wb_addr", last_wb_addr, 32'h1234_5680);
    chk("t1_upd", {last_upd_idx, last_upd_way, last_upd_mesi}, {14'h115A, 4'd3, 2'd2});
    chk("t1_counts", {n_msg, n_wb, n_upd}, {32'd1, 32'd1, 32'd1});

    // RWIM hit in E: HIT, INVALIDATELINE, E->I, no write-back.
    xact(3, 32'hABCD_0040, 1, 4'd0, 1);
    chk("t2_result", last_res, 1);
    chk("t2_counts", {n_msg, n_wb, n_upd}, {32'd1, 32'd0, 32'd1});
    chk("t2_upd", {last_mt, last_upd_mesi}, {2'd2, 2'd3});

    // READ miss: NOHIT, done in T+3.
    xact(0, 32'h0F0F_0F00, 0, 4'd5, 0);
    chk("t3_result", last_res, 0);
    chk("t3_done_d", done_d, 3);
    chk("t3_upd", n_upd, 0);

    // INVALIDATE hit in M.
    xact(2, 32'h5555_AAC0, 1, 4'd7, 0);
    if (PC) chk("t4_chk", {last_res, last_perr, 32'(n_upd), 32'(n_msg)}, {2'd0, 1'b1, 32'd0, 32'd0});
    else chk("t4_nochk", {last_res, last_perr, 32'(n_upd), last_upd_mesi, last_mt},
             {2'd1, 1'b0, 32'd1, 2'd3, 2'd2});

    // RWIM hit in M with stalled L1 and bus.
    msg_stall = 5; wb_stall = 3;
    xact(3, 32'h89AB_CDFF, 1, 4'd9, 0);
    chk("t5_result", last_res, 2);
    chk("t5_counts", {n_msg, n_wb, n_upd}, {32'd2, 32'd1, 32'd1});
    chk("t5_upd", {last_upd_way, last_upd_mesi, last_wb_addr}, {4'd9, 2'd3, 32'h89AB_CDC0});

    // Reset during a stalled write-back.
    wb_stall = 50;
    cur_hit = 1; cur_way = 2; cur_mesi = 0;
    snoop_op = 0; snoop_addr = 32'h2222_3340; snoop_valid = 1;
    old = wbvis; ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #2;
      if (acc_cnt > 0 && busy) snoop_valid = 0;
      ok = (wbvis != old);
    end
    chk("t6_wb_reached", ok, 1);
    snoop_valid = 0; rst = 1;
    @(posedge clk); #2;
    rst = 0; wb_stall = 0;
    repeat (3) @(posedge clk);
    #2;

    // Random traffic with random ready back-pressure.
    rnd_rdy = 1;
    for (int n = 0; n < 300; n++) begin
      logic h;
      h = 1'($urandom);
      xact(2'($urandom), $urandom, h, 4'($urandom), h ? 2'($urandom_range(0, 2)) : 2'($urandom));
    end
    rnd_rdy = 0;
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
